// File: rtl/cfg_pkg.sv
// System-wide configuration shared by the stk blocks.
package cfg_pkg;
  localparam int ENGS_N = 4;
endpackage

// File: rtl/stk_pkg.sv
// Sizing constants for the stk response path.
package stk_pkg;
  localparam int RSP_DEPTH = 4;
  localparam int RSP_SKID  = 2;
  localparam int RSP_DW    = 128;
endpackage

// File: rtl/stk_rsp_fifo.sv
// Single-lane response FIFO; the caller decides when push/pop are legal.
module stk_rsp_fifo
  import stk_pkg::*;
#(
  parameter int DEPTH = RSP_DEPTH,
  parameter int DW    = RSP_DW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [DW-1:0]              i_dat,
  output logic [DW-1:0]              o_dat,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !rst) r_mem[r_wr_ptr] <= i_dat;
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/stk_rsp_buf.sv
// Per-engine response buffering with overflow/multi-hot flags and
// registered command throttling that reserves room for in-flight responses.
module stk_rsp_buf
  import stk_pkg::*;
#(
  parameter int ENGS_N = cfg_pkg::ENGS_N,
  parameter int DEPTH  = RSP_DEPTH,
  parameter int SKID   = RSP_SKID
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ENGS_N-1:0]        i_rsp_vld,
  input  logic [RSP_DW-1:0]        i_rsp_dat,
  output logic [ENGS_N-1:0]        o_eng_vld,
  output logic [ENGS_N*RSP_DW-1:0] o_eng_dat,
  input  logic [ENGS_N-1:0]        i_eng_rdy,
  output logic [ENGS_N-1:0]        o_cmd_blk,
  output logic                     o_ovf,
  output logic                     o_err_mhot
);
  localparam int CW = $clog2(DEPTH+1);
  typedef logic [CW:0] cnt_ext_t;

  logic [ENGS_N-1:0] w_push;
  logic [ENGS_N-1:0] w_pop;
  logic [ENGS_N-1:0] w_drop;
  logic [ENGS_N-1:0] w_full;
  logic [ENGS_N-1:0] w_empty;
  logic [ENGS_N-1:0] w_blk_next;
  logic [CW-1:0]     w_count      [ENGS_N];
  logic [CW-1:0]     w_count_next [ENGS_N];
  logic              w_mhot;

  logic [ENGS_N-1:0] r_cmd_blk;
  logic              r_ovf;
  logic              r_mhot;

  genvar gi;
  generate
    for (gi = 0; gi < ENGS_N; gi++) begin : g_lane
      // A pop frees a slot in the same cycle, so a full lane can still accept.
      assign w_pop[gi]  = !w_empty[gi] && i_eng_rdy[gi];
      assign w_push[gi] = i_rsp_vld[gi] && (!w_full[gi] || w_pop[gi]);
      assign w_drop[gi] = i_rsp_vld[gi] && w_full[gi] && !w_pop[gi];

      assign w_count_next[gi] = w_count[gi] + CW'(w_push[gi]) - CW'(w_pop[gi]);
      assign w_blk_next[gi]   = (cnt_ext_t'(DEPTH) - cnt_ext_t'(w_count_next[gi]))
                                <= cnt_ext_t'(SKID);

      assign o_eng_vld[gi] = !w_empty[gi];

      stk_rsp_fifo #(
        .DEPTH (DEPTH),
        .DW    (RSP_DW)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push[gi]),
        .i_pop   (w_pop[gi]),
        .i_dat   (i_rsp_dat),
        .o_dat   (o_eng_dat[gi*RSP_DW +: RSP_DW]),
        .o_count (w_count[gi]),
        .o_full  (w_full[gi]),
        .o_empty (w_empty[gi])
      );
    end
  endgenerate

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign w_mhot = (i_rsp_vld & (i_rsp_vld - ENGS_N'(1))) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_blk <= '0;
      r_ovf     <= 1'b0;
      r_mhot    <= 1'b0;
    end else begin
      r_cmd_blk <= w_blk_next;
      r_ovf     <= r_ovf | (|w_drop);
      r_mhot    <= r_mhot | w_mhot;
    end
  end

  assign o_cmd_blk  = r_cmd_blk;
  assign o_ovf      = r_ovf;
  assign o_err_mhot = r_mhot;
endmodule

// File: tb/tb_stk_rsp_buf.sv
// Self-checking bench: directed vector table plus randomized traffic, with a
// per-lane queue scoreboard checking delivered data order.
module tb_stk_rsp_buf;
  localparam int ENGS  = 4;
  localparam int DEPTH = 4;
  localparam int SKID  = 2;

  logic              clk;
  logic              rst;
  logic [ENGS-1:0]   i_rsp_vld;
  logic [127:0]      i_rsp_dat;
  logic [ENGS-1:0]   o_eng_vld;
  logic [ENGS*128-1:0] o_eng_dat;
  logic [ENGS-1:0]   i_eng_rdy;
  logic [ENGS-1:0]   o_cmd_blk;
  logic              o_ovf;
  logic              o_err_mhot;

  stk_rsp_buf #(.ENGS_N(ENGS), .DEPTH(DEPTH), .SKID(SKID)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rsp_vld  (i_rsp_vld),
    .i_rsp_dat  (i_rsp_dat),
    .o_eng_vld  (o_eng_vld),
    .o_eng_dat  (o_eng_dat),
    .i_eng_rdy  (i_eng_rdy),
    .o_cmd_blk  (o_cmd_blk),
    .o_ovf      (o_ovf),
    .o_err_mhot (o_err_mhot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [3:0]   vld;
    logic [127:0] dat;
    logic [3:0]   rdy;
    logic [3:0]   e_vld;
    logic [3:0]   e_blk;
    logic         e_ovf;
    logic         e_mh;
  } vec_t;

  vec_t         tv [33];
  logic [127:0] sb_q [ENGS][$];
  logic         m_ovf;
  logic         m_mh;
  int           n_chk;
  int           n_pass;

  function automatic vec_t mk(logic r, logic [3:0] v, logic [127:0] d, logic [3:0] y,
                              logic [3:0] ev, logic [3:0] eb, logic eo, logic em);
    vec_t t;
    t.rst = r; t.vld = v; t.dat = d; t.rdy = y;
    t.e_vld = ev; t.e_blk = eb; t.e_ovf = eo; t.e_mh = em;
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    else n_pass++;
  endtask

  // One clock: drive, score pops against the model, update model, compare outputs.
  task automatic step(input logic r, input logic [3:0] v, input logic [127:0] d,
                      input logic [3:0] y);
    logic [127:0] exp_d;
    logic [3:0]   m_vld;
    logic [3:0]   m_blk;
    @(negedge clk);
    rst = r; i_rsp_vld = v; i_rsp_dat = d; i_eng_rdy = y;
    #1;
    if (r) begin
      for (int e = 0; e < ENGS; e++) sb_q[e].delete();
      m_ovf = 1'b0;
      m_mh  = 1'b0;
    end else begin
      for (int e = 0; e < ENGS; e++) begin
        if (sb_q[e].size() > 0 && y[e]) begin
          exp_d = sb_q[e].pop_front();
          chk($sformatf("dat_lane%0d", e), o_eng_dat[e*128 +: 128], exp_d);
        end
        if (v[e]) begin
          if (sb_q[e].size() < DEPTH) sb_q[e].push_back(d);
          else m_ovf = 1'b1;
        end
      end
      if ((v & (v - 4'd1)) != 4'd0) m_mh = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int e = 0; e < ENGS; e++) begin
      m_vld[e] = sb_q[e].size() != 0;
      m_blk[e] = (DEPTH - sb_q[e].size()) <= SKID;
    end
    $display("t=%0t rst=%0b vld=%b dat=%0h rdy=%b -> eng_vld=%b blk=%b ovf=%0b mhot=%0b",
             $time, r, v, d[31:0], y, o_eng_vld, o_cmd_blk, o_ovf, o_err_mhot);
    chk("model_vld", 128'(o_eng_vld), 128'(m_vld));
    chk("model_blk", 128'(o_cmd_blk), 128'(m_blk));
    chk("model_ovf", 128'(o_ovf), 128'(m_ovf));
    chk("model_mhot", 128'(o_err_mhot), 128'(m_mh));
  endtask

  initial begin
    n_chk = 0; n_pass = 0; m_ovf = 1'b0; m_mh = 1'b0;
    rst = 1'b1; i_rsp_vld = '0; i_rsp_dat = '0; i_eng_rdy = '0;

    //            rst vld   dat     rdy    e_vld e_blk ovf mh
    tv[0]  = mk(1, 4'h0, 128'h0,  4'h0,  4'h0, 4'h0, 0, 0);
    tv[1]  = mk(0, 4'h2, 128'hA5, 4'h0,  4'h2, 4'h0, 0, 0);
    tv[2]  = mk(0, 4'h0, 128'h0,  4'h2,  4'h0, 4'h0, 0, 0);
    tv[3]  = mk(0, 4'h1, 128'h10, 4'h0,  4'h1, 4'h0, 0, 0);
    tv[4]  = mk(0, 4'h1, 128'h11, 4'h0,  4'h1, 4'h1, 0, 0);
    tv[5]  = mk(0, 4'h0, 128'h0,  4'h1,  4'h1, 4'h0, 0, 0);
    tv[6]  = mk(0, 4'h0, 128'h0,  4'h1,  4'h0, 4'h0, 0, 0);
    tv[7]  = mk(0, 4'h4, 128'h0,  4'h0,  4'h4, 4'h0, 0, 0);
    tv[8]  = mk(0, 4'h4, 128'h1,  4'h0,  4'h4, 4'h4, 0, 0);
    tv[9]  = mk(0, 4'h4, 128'h2,  4'h0,  4'h4, 4'h4, 0, 0);
    tv[10] = mk(0, 4'h4, 128'h3,  4'h0,  4'h4, 4'h4, 0, 0);
    tv[11] = mk(0, 4'h4, 128'h4,  4'h0,  4'h4, 4'h4, 1, 0);
    tv[12] = mk(0, 4'h0, 128'h0,  4'h4,  4'h4, 4'h4, 1, 0);
    tv[13] = mk(0, 4'h0, 128'h0,  4'h4,  4'h4, 4'h4, 1, 0);
    tv[14] = mk(0, 4'h0, 128'h0,  4'h4,  4'h4, 4'h0, 1, 0);
    tv[15] = mk(0, 4'h0, 128'h0,  4'h4,  4'h0, 4'h0, 1, 0);
    tv[16] = mk(1, 4'h0, 128'h0,  4'h0,  4'h0, 4'h0, 0, 0);
    tv[17] = mk(0, 4'h8, 128'h0,  4'h0,  4'h8, 4'h0, 0, 0);
    tv[18] = mk(0, 4'h8, 128'h1,  4'h0,  4'h8, 4'h8, 0, 0);
    tv[19] = mk(0, 4'h8, 128'h2,  4'h0,  4'h8, 4'h8, 0, 0);
    tv[20] = mk(0, 4'h8, 128'h3,  4'h0,  4'h8, 4'h8, 0, 0);
    tv[21] = mk(0, 4'h8, 128'h9,  4'h8,  4'h8, 4'h8, 0, 0);
    tv[22] = mk(0, 4'h0, 128'h0,  4'h8,  4'h8, 4'h8, 0, 0);
    tv[23] = mk(0, 4'h0, 128'h0,  4'h8,  4'h8, 4'h8, 0, 0);
    tv[24] = mk(0, 4'h0, 128'h0,  4'h8,  4'h8, 4'h0, 0, 0);
    tv[25] = mk(0, 4'h0, 128'h0,  4'h8,  4'h0, 4'h0, 0, 0);
    tv[26] = mk(0, 4'h5, 128'h7,  4'h0,  4'h5, 4'h0, 0, 1);
    tv[27] = mk(0, 4'h2, 128'h20, 4'h0,  4'h7, 4'h0, 0, 1);
    tv[28] = mk(0, 4'h2, 128'h21, 4'h0,  4'h7, 4'h2, 0, 1);
    tv[29] = mk(0, 4'h0, 128'h0,  4'h5,  4'h2, 4'h2, 0, 1);
    tv[30] = mk(1, 4'h8, 128'h55, 4'hF,  4'h0, 4'h0, 0, 0);
    tv[31] = mk(0, 4'h8, 128'h33, 4'h0,  4'h8, 4'h0, 0, 0);
    tv[32] = mk(0, 4'h0, 128'h0,  4'h8,  4'h0, 4'h0, 0, 0);

    for (int i = 0; i < 33; i++) begin
      step(tv[i].rst, tv[i].vld, tv[i].dat, tv[i].rdy);
      chk($sformatf("tv%0d_vld", i), 128'(o_eng_vld), 128'(tv[i].e_vld));
      chk($sformatf("tv%0d_blk", i), 128'(o_cmd_blk), 128'(tv[i].e_blk));
      chk($sformatf("tv%0d_ovf", i), 128'(o_ovf), 128'(tv[i].e_ovf));
      chk($sformatf("tv%0d_mhot", i), 128'(o_err_mhot), 128'(tv[i].e_mh));
    end

    // Randomized traffic with backpressure to exercise wrap and full push+pop.
    step(1'b1, 4'h0, 128'h0, 4'h0);
    for (int i = 0; i < 300; i++) begin
      logic [3:0]   v;
      logic [127:0] d;
      v = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3))
                                      : 4'($urandom_range(0, 1) ? $urandom_range(0, 15) : 0);
      d = {$urandom, $urandom, $urandom, $urandom};
      step(1'b0, v, d, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i <= DEPTH; i++) step(1'b0, 4'h0, 128'h0, 4'hF);
    chk("drained", 128'(o_eng_vld), 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
